axi_rd_arbiter: RTL and testbench

//  Shares the single AXI read channel (AR/R) between the I-cache refill port (req 0)
//  and the D-cache refill port (req 1). Round-robin arbitration, one outstanding burst.

---
 rtl/axi_rd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between I-cache and D-cache refill.
// Optional ARB_BEAT_CHECK_EN adds R-beat count / rid protocol checks.
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]             req_len,
    output logic [1:0]              req_ready,
    output logic [1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_last,
    output logic                    resp_err,
    output logic                    busy,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    arvalid_q, arvalid_d;
    logic                    pick;
    logic                    beat_bad;
    logic                    unused_ok;

    // Tie goes to whoever did not win last time
    assign pick = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

    assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, grant_q};
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = ARSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = arvalid_q;
    assign resp_data     = m_axi_rdata;
    assign busy          = (state_q != IDLE);
    assign unused_ok     = ^{m_axi_rid, m_axi_rresp[0]};

`ifdef ARB_BEAT_CHECK_EN
    logic [7:0] beat_cnt_q, beat_cnt_d;

    assign beat_bad = (m_axi_rlast && (beat_cnt_q != arlen_q))
                   || (!m_axi_rlast && (beat_cnt_q > arlen_q))
                   || (m_axi_rid != m_axi_arid);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == ADDR && m_axi_arready) begin
            beat_cnt_d = 8'd0;
        end else if (state_q == DATA && m_axi_rvalid && beat_cnt_q != 8'hff) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= 8'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            if (state_q == DATA && m_axi_rvalid && beat_bad) begin
                $error("axi_rd_arbiter: R burst protocol violation");
            end
        end
    end
`else
    assign beat_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        req_ready    = 2'b00;
        resp_valid   = 2'b00;
        resp_last    = 1'b0;
        resp_err     = 1'b0;
        m_axi_rready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d   = pick;
                    araddr_d  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                     : req_addr[ADDR_WIDTH-1:0];
                    arlen_d   = pick ? req_len[15:8] : req_len[7:0];
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    req_ready[grant_q] = 1'b1;
                    arvalid_d          = 1'b0;
                    last_grant_d       = grant_q;
                    state_d            = DATA;
                end
            end
            DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    resp_valid[grant_q] = 1'b1;
                    resp_last           = m_axi_rlast;
                    resp_err            = m_axi_rresp[1] | beat_bad;
                    if (m_axi_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            araddr_q     <= '0;
            arlen_q      <= 8'd0;
            arvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; R beats scored through an expected-beat queue.
// Compile with ARB_BEAT_CHECK_EN to expect flagged short bursts.
module tb_axi_rd_arbiter;

    localparam int IW = 13;
    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [2*AW-1:0] req_addr;
    logic [15:0]   req_len;
    logic [1:0]    req_ready;
    logic [1:0]    resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_last;
    logic          resp_err;
    logic          busy;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err), .busy(busy),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          g;
        logic          last;
        logic          err;
        logic [DW-1:0] data;
    } beat_t;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        beat_t e;
        if (reset === 1'b0 && resp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(resp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_valid", 64'(resp_valid), e.g ? 64'd2 : 64'd1);
                chk("beat_data", resp_data, e.data);
                chk("beat_last", 64'(resp_last), 64'(e.last));
                chk("beat_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        req_valid     = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [7:0] l);
        if (i == 0) begin
            req_addr[63:0] = a;
            req_len[7:0]   = l;
        end else begin
            req_addr[127:64] = a;
            req_len[15:8]    = l;
        end
        req_valid[i] = 1'b1;
    endtask

    // Expects the DUT in IDLE with req_valid already driven; ends one cycle into DATA
    task automatic grant(input logic g, input logic [63:0] a, input logic [7:0] l);
        sample();
        chk("idle_arvalid", 64'(m_axi_arvalid), 64'd0);
        tick();
        sample();
        chk("ar_valid", 64'(m_axi_arvalid), 64'd1);
        chk("ar_addr", m_axi_araddr, a);
        chk("ar_len", 64'(m_axi_arlen), 64'(l));
        chk("ar_id", 64'(m_axi_arid), 64'(g));
        chk("ar_wait_ready", 64'(req_ready), 64'd0);
        tick();
        m_axi_arready = 1'b1;
        sample();
        chk("req_ready", 64'(req_ready), g ? 64'd2 : 64'd1);
        tick();
        m_axi_arready = 1'b0;
        req_valid[g]  = 1'b0;
        sample();
        chk("data_rready", 64'(m_axi_rready), 64'd1);
        chk("data_arvalid", 64'(m_axi_arvalid), 64'd0);
        tick();
    endtask

    task automatic beat(input logic g, input logic [63:0] d, input logic last,
                        input logic [1:0] resp, input int gap, input logic exp_err);
        repeat (gap) begin
            m_axi_rvalid = 1'b0;
            tick();
        end
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = d;
        m_axi_rlast  = last;
        m_axi_rresp  = resp;
        m_axi_rid    = IW'(g);
        sb.push_back('{g: g, last: last, err: exp_err, data: d});
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    task automatic burst(input logic g, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            beat(g, base + 64'(i), (i == n - 1), 2'b00, 0, 1'b0);
        end
    endtask

    initial begin
        req_addr    = '0;
        req_len     = '0;
        m_axi_rid   = '0;
        m_axi_rdata = '0;
        do_reset();

        // Reset values and constants
        sample();
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_araddr", m_axi_araddr, 64'd0);
        chk("rst_arid", 64'(m_axi_arid), 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("arsize", 64'(m_axi_arsize), 64'd3);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        chk("ar_misc", 64'({m_axi_arlock, m_axi_arcache, m_axi_arprot}), 64'd0);
        tick();

        // 1: req0 alone, 8-beat burst
        set_req(0, 64'h1000, 8'd7);
        grant(1'b0, 64'h1000, 8'd7);
        burst(1'b0, 64'hA000, 8);
        sample();
        chk("t1_busy_after", 64'(busy), 64'd0);
        tick();

        // 2: tie from reset -> req0, then req1, then tie -> req0 again
        do_reset();
        set_req(0, 64'h1000, 8'd1);
        set_req(1, 64'h2000, 8'd1);
        grant(1'b0, 64'h1000, 8'd1);
        burst(1'b0, 64'hB000, 2);
        grant(1'b1, 64'h2000, 8'd1);
        burst(1'b1, 64'hB100, 2);
        set_req(0, 64'h1100, 8'd0);
        set_req(1, 64'h2100, 8'd0);
        grant(1'b0, 64'h1100, 8'd0);
        burst(1'b0, 64'hB200, 1);
        grant(1'b1, 64'h2100, 8'd0);
        burst(1'b1, 64'hB300, 1);

        // 3: stray R beat in IDLE ignored; arready low 5 cycles
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        sample();
        chk("idle_rready", 64'(m_axi_rready), 64'd0);
        chk("idle_resp_valid", 64'(resp_valid), 64'd0);
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        set_req(0, 64'h3000, 8'd2);
        sample();
        tick();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_arvalid", 64'(m_axi_arvalid), 64'd1);
            chk("stall_araddr", m_axi_araddr, 64'h3000);
            chk("stall_arlen", 64'(m_axi_arlen), 64'd2);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_rready", 64'(m_axi_rready), 64'd0);
            tick();
        end
        m_axi_arready = 1'b1;
        sample();
        chk("stall_hs", 64'(req_ready), 64'd1);
        tick();
        m_axi_arready = 1'b0;
        req_valid[0]  = 1'b0;
        burst(1'b0, 64'hC000, 3);

        // 4: gaps 0..3 between beats, SLVERR on beat 3 only
        set_req(1, 64'h4000, 8'd3);
        grant(1'b1, 64'h4000, 8'd3);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 64'hD000 + 64'(i), (i == 3), (i == 2) ? 2'b10 : 2'b00, i, (i == 2));
        end
        sample();
        chk("t4_busy_after", 64'(busy), 64'd0);
        tick();

        // 5: reset during beat 2 of 4
        set_req(0, 64'h5000, 8'd3);
        grant(1'b0, 64'h5000, 8'd3);
        beat(1'b0, 64'hE000, 1'b0, 2'b00, 0, 1'b0);
        reset        = 1'b1;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 64'hE001;
        tick();
        reset        = 1'b0;
        m_axi_rvalid = 1'b0;
        sample();
        chk("r5_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("r5_araddr", m_axi_araddr, 64'd0);
        chk("r5_arlen", 64'(m_axi_arlen), 64'd0);
        chk("r5_arid", 64'(m_axi_arid), 64'd0);
        chk("r5_rready", 64'(m_axi_rready), 64'd0);
        chk("r5_req_ready", 64'(req_ready), 64'd0);
        chk("r5_resp_valid", 64'(resp_valid), 64'd0);
        chk("r5_busy", 64'(busy), 64'd0);
        tick();
        set_req(1, 64'h6000, 8'd0);
        grant(1'b1, 64'h6000, 8'd0);
        burst(1'b1, 64'hF000, 1);

        // 6: rlast arrives early (beat 2 of a len-3 burst)
        set_req(0, 64'h7000, 8'd3);
        grant(1'b0, 64'h7000, 8'd3);
        beat(1'b0, 64'h7700, 1'b0, 2'b00, 0, 1'b0);
`ifdef ARB_BEAT_CHECK_EN
        beat(1'b0, 64'h7701, 1'b1, 2'b00, 0, 1'b1);
`else
        beat(1'b0, 64'h7701, 1'b1, 2'b00, 0, 1'b0);
`endif
        sample();
        chk("t6_busy_after", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
